// File: rtl/tty_pkg.sv
// Shared definitions for the text-mode console writer: geometry defaults, control codes, FSM states.
package tty_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 25;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PUT_CHAR,
        PUT_ATTR,
        SCROLL_RD,
        SCROLL_WR,
        CLR_CHAR,
        CLR_ATTR
    } state_t;

    // Codes that only move the cursor; every other byte is drawn as a glyph.
    function automatic logic is_motion(input logic [7:0] code);
        return (code == CR) || (code == LF) || (code == BS);
    endfunction

endpackage

// File: rtl/tty_writer_if.sv
// Host byte stream plus video RAM port of the console writer, bundled for the top-level port list.
interface tty_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attr;
    logic [11:0] address;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic [10:0] cursor;

    modport slave (
        input  in_data, in_valid, attr, rdata,
        output in_ready, address, wdata, we, cursor
    );

    modport master (
        output in_data, in_valid, attr, rdata,
        input  in_ready, address, wdata, we, cursor
    );
endinterface

// File: rtl/tty_scroller.sv
// Moves every text row up by one (read/write byte pairs) and then blanks the last row.
// Runs once per start pulse; done is high during the final clear cycle.
module tty_scroller
    import tty_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  attr,
    input  logic [7:0]  rdata,
    output logic        done,
    output logic        we,
    output logic [11:0] address,
    output logic [7:0]  wdata
);
    // MOVE_BYTES is also the byte address where the last row begins.
    localparam logic [11:0] MOVE_BYTES = 12'(2 * COLS * (ROWS - 1));
    localparam logic [11:0] SRC_OFFSET = 12'(2 * COLS);
    localparam logic [11:0] LAST_COL   = 12'(COLS - 1);

    state_t      phase, phase_next;
    logic [11:0] idx, idx_next;

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            phase <= IDLE;
            idx   <= '0;
        end else begin
            phase <= phase_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        phase_next = phase;
        idx_next   = idx;
        done       = 1'b0;
        we         = 1'b0;
        address    = '0;
        wdata      = '0;
        case (phase)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    phase_next = (MOVE_BYTES != 12'd0) ? SCROLL_RD : CLR_CHAR;
                end
            end
            SCROLL_RD: begin
                address    = idx + SRC_OFFSET;
                phase_next = SCROLL_WR;
            end
            SCROLL_WR: begin
                we      = 1'b1;
                address = idx;
                wdata   = rdata;
                if (idx == MOVE_BYTES - 12'd1) begin
                    idx_next   = '0;
                    phase_next = CLR_CHAR;
                end else begin
                    idx_next   = idx + 12'd1;
                    phase_next = SCROLL_RD;
                end
            end
            CLR_CHAR: begin
                we         = 1'b1;
                address    = MOVE_BYTES + {idx[10:0], 1'b0};
                wdata      = SPACE;
                phase_next = CLR_ATTR;
            end
            CLR_ATTR: begin
                we      = 1'b1;
                address = MOVE_BYTES + {idx[10:0], 1'b1};
                wdata   = attr;
                if (idx == LAST_COL) begin
                    done       = 1'b1;
                    phase_next = IDLE;
                end else begin
                    idx_next   = idx + 12'd1;
                    phase_next = CLR_CHAR;
                end
            end
            default: phase_next = IDLE;
        endcase
    end

endmodule

// File: rtl/tty_writer.sv
// Text-mode console writer: turns a host byte stream into character/attribute writes in video RAM.
// Optional macro TTY_SCROLL_EN: scroll the screen up on overflow instead of wrapping the cursor.
module tty_writer
    import tty_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic        clock_25,
    input  logic        reset_n,
    tty_writer_if.slave bus
);
    localparam logic [11:0] CELLS    = 12'(COLS * ROWS);
    localparam logic [11:0] ROW_STEP = 12'(COLS);

    state_t      state, state_next;
    logic [10:0] cursor_q, cursor_next;
    logic [10:0] column;
    logic [7:0]  code_q, attr_q;
    logic [11:0] target;
    logic        move;
    logic        accept;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign column     = 11'(32'(cursor_q) % COLS);
    assign bus.cursor = cursor_q;

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cursor_q <= '0;
            code_q   <= '0;
            attr_q   <= '0;
        end else begin
            state    <= state_next;
            cursor_q <= cursor_next;
            if (accept) begin
                code_q <= bus.in_data;
                attr_q <= bus.attr;
            end
        end
    end

`ifdef TTY_SCROLL_EN
    logic [10:0] resume_q;
    logic        scroll_start, scroll_done, scroll_we;
    logic [11:0] scroll_address;
    logic [7:0]  scroll_wdata;

    // The cursor holds still during a scroll; its landing spot is parked here until done.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            resume_q <= '0;
        end else if (scroll_start) begin
            resume_q <= 11'(target - ROW_STEP);
        end
    end

    tty_scroller #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) scroller (
        .clock_25 (clock_25),
        .reset_n  (reset_n),
        .start    (scroll_start),
        .attr     (attr_q),
        .rdata    (bus.rdata),
        .done     (scroll_done),
        .we       (scroll_we),
        .address  (scroll_address),
        .wdata    (scroll_wdata)
    );
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.rdata;
`endif

    // SCROLL_RD in this FSM means the scroller owns the RAM port until it reports done.
    always_comb begin
        state_next  = state;
        cursor_next = cursor_q;
        target      = {1'b0, cursor_q};
        move        = 1'b0;
`ifdef TTY_SCROLL_EN
        scroll_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_motion(bus.in_data)) begin
                        move = 1'b1;
                        if (bus.in_data == CR) begin
                            target = {1'b0, cursor_q - column};
                        end else if (bus.in_data == LF) begin
                            target = {1'b0, cursor_q} + ROW_STEP;
                        end else if (column != 11'd0) begin
                            target = {1'b0, cursor_q} - 12'd1;
                        end
                    end else begin
                        state_next = PUT_CHAR;
                    end
                end
            end
            PUT_CHAR: state_next = PUT_ATTR;
            PUT_ATTR: begin
                move       = 1'b1;
                target     = {1'b0, cursor_q} + 12'd1;
                state_next = IDLE;
            end
`ifdef TTY_SCROLL_EN
            SCROLL_RD: begin
                if (scroll_done) begin
                    state_next  = IDLE;
                    cursor_next = resume_q;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        if (move) begin
            if (target >= CELLS) begin
`ifdef TTY_SCROLL_EN
                scroll_start = 1'b1;
                state_next   = SCROLL_RD;
`else
                cursor_next = 11'(target - CELLS);
`endif
            end else begin
                cursor_next = target[10:0];
            end
        end
    end

    always_comb begin
        bus.in_ready = (state == IDLE);
        bus.we       = 1'b0;
        bus.address  = '0;
        bus.wdata    = '0;
        case (state)
            PUT_CHAR: begin
                bus.we      = 1'b1;
                bus.address = {cursor_q, 1'b0};
                bus.wdata   = code_q;
            end
            PUT_ATTR: begin
                bus.we      = 1'b1;
                bus.address = {cursor_q, 1'b1};
                bus.wdata   = attr_q;
            end
`ifdef TTY_SCROLL_EN
            SCROLL_RD: begin
                bus.we      = scroll_we;
                bus.address = scroll_address;
                bus.wdata   = scroll_wdata;
            end
`endif
            default: ;
        endcase
    end

endmodule
